multdiv_iter: RTL and testbench
===============================

MULTDIV_ITER -- requirements
Module: multdiv_iter

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 SHALL have port: ctrl_MULT  input  1  one-cycle start pulse for a multiply.
REQ-004 SHALL have port: ctrl_DIV  input  1  one-cycle start pulse for a divide.
REQ-005 SHALL have port: data_operandA  input  32  multiplicand / dividend, two's complement.
REQ-006 SHALL have port: data_operandB  input  32  multiplier / divisor, two's complement.
REQ-007 SHALL have port: data_result  output  32  product low word or quotient.
REQ-008 SHALL have port: data_exception  output  1  overflow or divide-by-zero flag for the current result.
REQ-009 SHALL have port: data_resultRDY  output  1  one-cycle completion pulse (the pipeline's md_rdy).
REQ-010 SHALL have exactly one clock; reset SHALL be synchronous and active-high.

Function
REQ-011 SHALL implement states IDLE, MULT, DIV, DONE.
REQ-012 SHALL accept a start only in IDLE: ctrl_MULT -> MULT, else ctrl_DIV -> DIV.
REQ-013 SHALL treat ctrl_MULT and ctrl_DIV high together as a multiply.
REQ-014 SHALL ignore start pulses in MULT, DIV and DONE, with no effect on the operation in flight.
REQ-015 SHALL latch data_operandA and data_operandB on the accepting edge; later operand changes SHALL NOT affect the result.
REQ-016 SHALL perform exactly one iteration per cycle for 32 cycles, using a 5-bit iteration counter (0..31).
REQ-017 SHALL transition MULT/DIV -> DONE after the 32nd iteration, and DONE -> IDLE after one cycle.
REQ-018 Timing: if the start is accepted at edge N, the iterations SHALL occur at edges N+1..N+32.
REQ-019 At edge N+33, data_result and data_exception SHALL be registered and data_resultRDY SHALL go high.
REQ-020 data_resultRDY SHALL go low at edge N+34; it SHALL be high for exactly one cycle per accepted start.
REQ-021 data_result and data_exception SHALL hold their values from edge N+33 until the next completion or reset.
REQ-022 Multiply SHALL use a signed shift-add algorithm (Booth radix-2 permitted) with a 64-bit product.
REQ-023 Multiply result SHALL be product[31:0].
REQ-024 Multiply exception SHALL be 1 iff the 64-bit product is not the sign extension of product[31:0].
REQ-025 Divide SHALL be signed restoring or non-restoring division on operand magnitudes.
REQ-026 Divide quotient SHALL truncate toward zero and be negated iff the operand signs differ; the remainder SHALL be discarded.
REQ-027 Divisor 0 SHALL give result 0 and exception 1, with the full 33-cycle latency.
REQ-028 0x80000000 / 0xFFFFFFFF SHALL give result 0x80000000 and exception 1.
REQ-029 Magnitude of 0x80000000 SHALL be handled as unsigned 2^31 internally, with no spurious exception when the product or quotient fits.
REQ-030 Outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-031 Reset SHALL force state IDLE, counter 0, data_result 0, data_exception 0 and data_resultRDY 0.
REQ-032 Reset asserted mid-operation SHALL abort the operation with no data_resultRDY pulse for it.
REQ-033 Reset SHALL take priority over a start pulse in the same cycle.
REQ-034 A start in the first cycle after reset deasserts SHALL be accepted.

Verification
REQ-035 Multiply: ctrl_MULT with A=6, B=-7 -> at N+33, RDY=1, result=0xFFFFFFD6, exception=0; RDY=0 at N+34.
REQ-036 Multiply overflow: A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1; and A=0x80000000, B=1 -> result=0x80000000, exception=0.
REQ-037 Divide: A=-100, B=7 -> result=0xFFFFFFF2 (-14), exception=0; A=100, B=0 -> result=0, exception=1; A=0x80000000, B=-1 -> result=0x80000000, exception=1.
REQ-038 Busy rejection: ctrl_DIV pulses at N+5 and at N+33 (DONE) during a multiply -> exactly one RDY pulse at N+33, carrying the multiply result, then IDLE.
REQ-039 Reset mid-op: reset at N+10 during a divide -> all outputs 0 from N+10, no RDY; a new start at N+12 completes at N+45.
REQ-040 Back-to-back: a start in the IDLE cycle right after RDY -> second RDY exactly 34 cycles after the first, and operands changed after acceptance are ignored.

Source files
------------

// File: rtl/multdiv_iter.sv
// =============================================================================
// Module   : multdiv_iter
// Brief    : Iterative signed 32x32 multiply / 32/32 divide, one step per cycle.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module multdiv_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_b;

    // Operand magnitudes; 0x80000000 maps to unsigned 2^31.
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    assign w_mag_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
    assign w_mag_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

    // Multiply step: {hi,lo} is the unsigned product, multiplier bits shift out of lo.
    logic [32:0] w_msum;
    assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);

    // Divide step (restoring): hi is the partial remainder, lo collects quotient bits.
    logic [32:0] w_dshift;
    logic [32:0] w_ddiff;
    assign w_dshift = {r_hi, r_lo[31]};
    assign w_ddiff  = w_dshift - {1'b0, r_b};

    logic [63:0] w_prod_u;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic        w_mult_ovf;
    assign w_prod_u   = {r_hi, r_lo};
    assign w_prod     = r_neg ? (~w_prod_u + 64'd1) : w_prod_u;
    assign w_quot     = r_neg ? (~r_lo + 32'd1) : r_lo;
    assign w_mult_ovf = (w_prod[63:32] != {32{w_prod[31]}});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= 5'd0;
            r_is_div       <= 1'b0;
            r_neg          <= 1'b0;
            r_hi           <= 32'd0;
            r_lo           <= 32'd0;
            r_b            <= 32'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ctrl_MULT || ctrl_DIV) begin
                        r_state  <= ctrl_MULT ? MULT : DIV;
                        r_is_div <= !ctrl_MULT;
                        r_neg    <= data_operandA[31] ^ data_operandB[31];
                        r_hi     <= 32'd0;
                        r_lo     <= w_mag_a;
                        r_b      <= w_mag_b;
                        r_cnt    <= 5'd0;
                    end
                end
                MULT: begin
                    r_hi  <= w_msum[32:1];
                    r_lo  <= {w_msum[0], r_lo[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= DONE;
                    end
                end
                DIV: begin
                    if (!w_ddiff[32]) begin
                        r_hi <= w_ddiff[31:0];
                        r_lo <= {r_lo[30:0], 1'b1};
                    end else begin
                        r_hi <= w_dshift[31:0];
                        r_lo <= {r_lo[30:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    data_resultRDY <= 1'b1;
                    r_state        <= IDLE;
                    if (r_is_div) begin
                        if (r_b == 32'd0) begin
                            data_result    <= 32'd0;
                            data_exception <= 1'b1;
                        end else begin
                            // Only a positive 2^31 quotient is unrepresentable.
                            data_result    <= w_quot;
                            data_exception <= !r_neg && r_lo[31];
                        end
                    end else begin
                        data_result    <= w_prod[31:0];
                        data_exception <= w_mult_ovf;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_iter.sv
// =============================================================================
// Module   : tb_multdiv_iter
// Brief    : Self-checking bench for multdiv_iter against an arithmetic model.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_multdiv_iter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_res  = 32'd0;
    logic        exp_exc  = 1'b0;

    multdiv_iter dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint sa;
        longint sb;
        longint p;
        longint q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p = sa * sb;
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else begin
            q = sa / sb;
            r = q[31:0];
            e = (q > 64'sd2147483647);
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic rdy_exp);
        check({tag, "_rdy"}, {31'd0, data_resultRDY}, {31'd0, rdy_exp});
        check({tag, "_res"}, data_result, exp_res);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
    endtask

    // One operation: accept edge N (skipped when a previous op already started it),
    // 32 busy edges, completion at N+33, idle at N+34 (optionally accepting the next op).
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input bit prestarted, input bit poke, input bit chain,
                          input bit nx_div, input logic [31:0] nx_a, input logic [31:0] nx_b,
                          input string tag);
        logic [31:0] r;
        logic        e;
        model(is_div, a, b, r, e);
        if (!prestarted) begin
            ctrl_MULT     = !is_div;
            ctrl_DIV      = is_div;
            data_operandA = a;
            data_operandB = b;
            tick();
        end
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        for (int k = 1; k <= 32; k++) begin
            ctrl_DIV = poke && (k == 5);
            tick();
            check_outputs({tag, "_busy"}, 1'b0);
            if (k % 7 == 0) begin
                data_operandA = $urandom;
                data_operandB = $urandom;
            end
        end
        ctrl_DIV = poke;
        tick();
        ctrl_DIV = 1'b0;
        exp_res  = r;
        exp_exc  = e;
        check_outputs({tag, "_done"}, 1'b1);
        if (chain) begin
            ctrl_MULT     = !nx_div;
            ctrl_DIV      = nx_div;
            data_operandA = nx_a;
            data_operandB = nx_b;
        end
        tick();
        check_outputs({tag, "_after"}, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        tick();
        tick();
        check_outputs("reset", 1'b0);

        // Start in the very first cycle after reset release.
        reset = 1'b0;
        run_op(0, 32'd6, 32'hFFFF_FFF9, 0, 0, 0, 0, 0, 0, "mul_6x-7");
        run_op(0, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 0, 0, 0, "mul_ovf");
        run_op(0, 32'h8000_0000, 32'd1, 0, 0, 0, 0, 0, 0, "mul_min");
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, "mul_min_neg");
        run_op(1, 32'hFFFF_FF9C, 32'd7, 0, 0, 0, 0, 0, 0, "div_-100_7");
        run_op(1, 32'd100, 32'd0, 0, 0, 0, 0, 0, 0, "div_zero");
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, "div_ovf");
        run_op(1, 32'h8000_0000, 32'd1, 0, 0, 0, 0, 0, 0, "div_min");

        // Start pulses while busy and in DONE must be ignored.
        run_op(0, 32'd12345, 32'hFFFF_FFFD, 0, 1, 0, 0, 0, 0, "busy");
        for (int k = 0; k < 36; k++) begin
            tick();
            check_outputs("busy_idle", 1'b0);
        end

        // Back-to-back: second start accepted in the cycle RDY is high.
        run_op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0, 1, 1, 32'd1000, 32'hFFFF_FFFD, "b2b_1");
        run_op(1, 32'd1000, 32'hFFFF_FFFD, 1, 0, 0, 0, 0, 0, "b2b_2");

        // Reset mid-divide, with a competing start pulse that reset must override.
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd999;
        data_operandB = 32'd3;
        tick();
        ctrl_DIV = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_outputs("pre_rst", 1'b0);
        end
        reset     = 1'b1;
        ctrl_MULT = 1'b1;
        tick();
        exp_res = 32'd0;
        exp_exc = 1'b0;
        check_outputs("rst_mid", 1'b0);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        tick();
        check_outputs("rst_gap", 1'b0);
        run_op(1, 32'hFFFF_F000, 32'd10, 0, 0, 0, 0, 0, 0, "after_rst");

        for (int i = 0; i < 16; i++) begin
            bit          is_div;
            logic [31:0] a;
            logic [31:0] b;
            is_div = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 2000) - 1000; b = $urandom_range(0, 60) - 30; end
                2: begin a = $urandom; b = $urandom_range(0, 2000) - 1000; end
                default: begin a = $urandom; b = 32'd0; end
            endcase
            run_op(is_div, a, b, 0, 0, 0, 0, 0, 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
